// File: rtl/mem_access_arb_if.sv
// Request/response bundle between the two requesters (A, B) and the memory arbiter.
// Status outputs (init_busy, init_done, err) travel with the bus so a requester sees them.
interface mem_access_arb_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [WIDTH-1:0]  a_wdata;
   logic              a_gnt;
   logic              a_rvalid;
   logic [WIDTH-1:0]  a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [WIDTH-1:0]  b_wdata;
   logic              b_gnt;
   logic              b_rvalid;
   logic [WIDTH-1:0]  b_rdata;

   logic              init_busy;
   logic              init_done;
   logic              err;

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      input  a_gnt, a_rvalid, a_rdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  init_busy, init_done, err
   );

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      output a_gnt, a_rvalid, a_rdata,
      output b_gnt, b_rvalid, b_rdata,
      output init_busy, init_done, err
   );
endinterface

// File: rtl/mem_access_arb.sv
// Owns a DEPTH x WIDTH register-file memory (indices LO..LO+DEPTH-1), fills it with
// mem[i] = i after reset, then serves requesters A and B one access per cycle, round-robin.
module mem_access_arb #(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 32,
   parameter int LO     = 1,
   parameter int ADDR_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   mem_access_arb_if.slave  bus
);
   typedef enum logic {ST_INIT, ST_RUN} state_e;

   localparam logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(LO);
   localparam logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(LO + DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              rr_b_q, rr_b_d;      // 1: B wins the next tie
   logic              a_rvalid_q, a_rvalid_d;
   logic              b_rvalid_q, b_rvalid_d;
   logic [WIDTH-1:0]  a_rdata_q, a_rdata_d;
   logic [WIDTH-1:0]  b_rdata_q, b_rdata_d;
   logic              err_q, err_d;

   logic [WIDTH-1:0]  mem_q [LO:LO+DEPTH-1];

   logic              a_gnt, b_gnt;
   logic              acc_we, acc_in_range;
   logic [ADDR_W-1:0] acc_addr;
   logic [WIDTH-1:0]  acc_wdata, rd_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WIDTH-1:0]  mem_wdata;

   // Grants are combinational so the access lands on the same edge the grant is seen.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (state_q == ST_RUN && !reset) begin
         a_gnt = bus.a_req && (!bus.b_req || !rr_b_q);
         b_gnt = bus.b_req && (!bus.a_req ||  rr_b_q);
      end
   end

   assign acc_we       = b_gnt ? bus.b_we    : bus.a_we;
   assign acc_addr     = b_gnt ? bus.b_addr  : bus.a_addr;
   assign acc_wdata    = b_gnt ? bus.b_wdata : bus.a_wdata;
   assign acc_in_range = (acc_addr >= ADDR_LO) && (acc_addr <= ADDR_HI);
   assign rd_data      = acc_in_range ? mem_q[acc_addr] : '0;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      rr_b_d     = rr_b_q;
      a_rvalid_d = 1'b0;
      b_rvalid_d = 1'b0;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      err_d      = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = acc_addr;
      mem_wdata  = acc_wdata;
      case (state_q)
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = WIDTH'(ptr_q);
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == ADDR_HI) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (a_gnt || b_gnt) begin
               rr_b_d = a_gnt;
               err_d  = !acc_in_range;
               mem_we = acc_we && acc_in_range;
               if (!acc_we) begin
                  a_rvalid_d = a_gnt;
                  b_rvalid_d = b_gnt;
                  if (a_gnt) a_rdata_d = rd_data;
                  else       b_rdata_d = rd_data;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         ptr_q      <= ADDR_LO;
         rr_b_q     <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rr_b_q     <= rr_b_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
         err_q      <= err_d;
      end
   end

   // NOTE: the array has no reset; the post-reset fill is what initialises it.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
   end

   assign bus.a_gnt     = a_gnt;
   assign bus.b_gnt     = b_gnt;
   assign bus.a_rvalid  = a_rvalid_q;
   assign bus.b_rvalid  = b_rvalid_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.b_rdata   = b_rdata_q;
   assign bus.err       = err_q;
   assign bus.init_busy = (state_q == ST_INIT);
   assign bus.init_done = (state_q == ST_RUN);
endmodule

// File: tb/tb_mem_access_arb.sv
// Self-checking bench for mem_access_arb: vector table for RUN traffic, a scoreboard queue
// for rvalid/rdata/err, and hand-written sequences for fill timing and mid-fill reset.
module tb_mem_access_arb;
   localparam int DEPTH  = 16;
   localparam int WIDTH  = 32;
   localparam int LO     = 1;
   localparam int ADDR_W = 5;

   typedef struct {
      logic              a_req;
      logic              a_we;
      logic [ADDR_W-1:0] a_addr;
      logic [WIDTH-1:0]  a_wdata;
      logic              b_req;
      logic              b_we;
      logic [ADDR_W-1:0] b_addr;
      logic [WIDTH-1:0]  b_wdata;
      logic              exp_a_gnt;
      logic              exp_b_gnt;
   } vec_t;

   typedef struct {
      logic             port_b;
      logic             is_read;
      logic [WIDTH-1:0] data;
      logic             err;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_access_arb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   mem_access_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LO(LO), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   vec_t             vecs[$];
   exp_t             exp_q[$];
   exp_t             mon_e;
   logic [WIDTH-1:0] ref_mem [LO:LO+DEPTH-1];
   logic [WIDTH-1:0] last_a = '0;
   logic [WIDTH-1:0] last_b = '0;
   int               n_checks = 0;
   int               n_pass   = 0;
   int               busy_cnt;
   bit               mon_en   = 1'b0;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
   endtask

   function automatic void add_vec(
      input logic ar, input logic aw, input logic [ADDR_W-1:0] aa, input logic [WIDTH-1:0] ad,
      input logic br, input logic bw, input logic [ADDR_W-1:0] ba, input logic [WIDTH-1:0] bd,
      input logic ga, input logic gb);
      vec_t v;
      v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
      v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
      v.exp_a_gnt = ga; v.exp_b_gnt = gb;
      vecs.push_back(v);
   endfunction

   // Reference memory model: predicts the response to one granted access.
   function automatic void model_access(input logic port_b, input logic we,
                                        input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wdata);
      exp_t e;
      logic in_r;
      in_r      = (int'(addr) >= LO) && (int'(addr) <= LO + DEPTH - 1);
      e.port_b  = port_b;
      e.is_read = !we;
      e.err     = !in_r;
      e.data    = '0;
      if (in_r) begin
         if (we) ref_mem[addr] = wdata;
         else    e.data = ref_mem[addr];
      end
      exp_q.push_back(e);
   endfunction

   function automatic void ref_fill();
      for (int i = LO; i <= LO + DEPTH - 1; i++) ref_mem[i] = WIDTH'(i);
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge right after reset release; counts busy cycles until the first RUN cycle.
   task automatic run_fill(input bit raise_b);
      bit done;
      done     = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (raise_b && c == 1) begin
            bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 5'd5;
         end
         #1;
         if (bus.init_busy) begin
            busy_cnt++;
            check("fill_no_a_gnt", bus.a_gnt, 0);
            check("fill_no_b_gnt", bus.b_gnt, 0);
         end else begin
            done = 1'b1;
         end
         if (!done) step();
      end
      check("fill_busy_cycles", busy_cnt, DEPTH);
      check("fill_init_done", bus.init_done, 1);
   endtask

   // Scoreboard consumer: one entry per granted access, checked one cycle after the grant edge.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("a_rvalid", bus.a_rvalid, mon_e.is_read && !mon_e.port_b);
            check("b_rvalid", bus.b_rvalid, mon_e.is_read &&  mon_e.port_b);
            check("err",      bus.err,      mon_e.err);
            if (mon_e.is_read && !mon_e.port_b) begin
               check("a_rdata", bus.a_rdata, mon_e.data);
               check("b_rdata_hold", bus.b_rdata, last_b);
               last_a = mon_e.data;
            end else if (mon_e.is_read) begin
               check("b_rdata", bus.b_rdata, mon_e.data);
               check("a_rdata_hold", bus.a_rdata, last_a);
               last_b = mon_e.data;
            end
         end else if (bus.a_rvalid || bus.b_rvalid || bus.err) begin
            check("spurious_pulse", {bus.a_rvalid, bus.b_rvalid, bus.err}, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;

      // Contention: rr points at A after the B grant that ends the fill phase.
      for (int i = 0; i < 6; i++)
         add_vec(1, 0, 5'd1, '0, 1, 0, 5'd2, '0, (i % 2) == 0, (i % 2) == 1);
      // Fill readback 1..16 by A alone, back-to-back.
      for (int i = LO; i <= LO + DEPTH - 1; i++)
         add_vec(1, 0, ADDR_W'(i), '0, 0, 0, '0, '0, 1, 0);
      // Write then read-after-write from the other port.
      add_vec(1, 1, 5'd7, 32'hDEADBEEF, 0, 0, '0, '0, 1, 0);
      add_vec(0, 0, '0, '0, 1, 0, 5'd7, '0, 0, 1);
      // Out-of-range write and read, then boundary entries.
      add_vec(1, 1, 5'd0, 32'h12345678, 0, 0, '0, '0, 1, 0);
      add_vec(1, 0, 5'd17, '0, 0, 0, '0, '0, 1, 0);
      add_vec(1, 0, 5'd1, '0, 0, 0, '0, '0, 1, 0);
      add_vec(1, 0, 5'd16, '0, 0, 0, '0, '0, 1, 0);
      // Tie with rr on B, then A follows; B's write to 16 must be visible next.
      add_vec(1, 0, 5'd7, '0, 1, 1, 5'd16, 32'hCAFE0016, 0, 1);
      add_vec(1, 0, 5'd7, '0, 0, 0, '0, '0, 1, 0);
      add_vec(1, 0, 5'd16, '0, 0, 0, '0, '0, 1, 0);
      // B out of range, B sustained, then idle.
      add_vec(0, 0, '0, '0, 1, 0, 5'd31, '0, 0, 1);
      add_vec(0, 0, '0, '0, 1, 0, 5'd3, '0, 0, 1);
      add_vec(0, 0, '0, '0, 1, 0, 5'd3, '0, 0, 1);
      add_vec(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.a_req = 1; bus.b_req = 1;
      #1;
      check("rst_a_gnt", bus.a_gnt, 0);
      check("rst_b_gnt", bus.b_gnt, 0);
      check("rst_a_rvalid", bus.a_rvalid, 0);
      check("rst_b_rvalid", bus.b_rvalid, 0);
      check("rst_a_rdata", bus.a_rdata, 0);
      check("rst_b_rdata", bus.b_rdata, 0);
      check("rst_err", bus.err, 0);
      check("rst_init_busy", bus.init_busy, 1);
      check("rst_init_done", bus.init_done, 0);
      bus.a_req = 0; bus.b_req = 0;
      mon_en = 1'b1;
      reset  = 1'b0;

      // Fill with b_req raised at fill cycle 2 and held.
      run_fill(1'b1);
      check("first_run_b_gnt", bus.b_gnt, 1);
      check("first_run_a_gnt", bus.a_gnt, 0);
      ref_fill();
      model_access(1'b1, 1'b0, 5'd5, '0);
      step();
      bus.b_req = 0;

      foreach (vecs[k]) begin
         bus.a_req = vecs[k].a_req; bus.a_we = vecs[k].a_we;
         bus.a_addr = vecs[k].a_addr; bus.a_wdata = vecs[k].a_wdata;
         bus.b_req = vecs[k].b_req; bus.b_we = vecs[k].b_we;
         bus.b_addr = vecs[k].b_addr; bus.b_wdata = vecs[k].b_wdata;
         #1;
         check($sformatf("vec%0d_a_gnt", k), bus.a_gnt, vecs[k].exp_a_gnt);
         check($sformatf("vec%0d_b_gnt", k), bus.b_gnt, vecs[k].exp_b_gnt);
         if (vecs[k].exp_a_gnt)
            model_access(1'b0, vecs[k].a_we, vecs[k].a_addr, vecs[k].a_wdata);
         else if (vecs[k].exp_b_gnt)
            model_access(1'b1, vecs[k].b_we, vecs[k].b_addr, vecs[k].b_wdata);
         step();
      end
      bus.a_req = 0; bus.b_req = 0; bus.a_we = 0; bus.b_we = 0;
      step();
      step();

      // Reset, then reset again on fill cycle 5 while a_req is held.
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'd3;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("midfill_a_gnt", bus.a_gnt, 0);
         check("midfill_busy", bus.init_busy, 1);
         step();
      end
      reset = 1'b1;
      #1;
      check("midfill_rst_a_gnt", bus.a_gnt, 0);
      step();
      reset  = 1'b0;
      last_a = '0;
      last_b = '0;
      run_fill(1'b0);
      check("refill_a_gnt", bus.a_gnt, 1);
      ref_fill();
      for (int i = LO; i <= LO + DEPTH - 1; i++)
         check($sformatf("mem_%0d", i), dut.mem_q[i], WIDTH'(i));
      model_access(1'b0, 1'b0, 5'd3, '0);
      step();
      bus.a_req = 0;
      step();
      step();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_access_arb.md
# mem_access_arb

Arbiter and sequencer for the 16-entry × 32-bit public register-file memory (index range 1..16) that the VPI/DPI memory tests inspect. After reset it fills every entry with its own index (mem[i] = i), then shares single-port access between two requesters, A and B, using round-robin arbitration. It owns the storage array, so a bench can check its contents through the public-memory path.

## Interface
- DEPTH, 16, number of entries
- WIDTH, 32, data width in bits
- LO, 1, lowest valid index; valid range is LO..LO+DEPTH-1
- ADDR_W, 5, address width; must hold LO+DEPTH

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- a_req, b_req  in  1  access request; held stable with its fields until granted
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  ADDR_W  entry index
- a_wdata, b_wdata  in  WIDTH  write data
- a_gnt, b_gnt  out  1  combinational grant; the access happens on this edge
- a_rvalid, b_rvalid  out  1  read data valid, one-cycle pulse
- a_rdata, b_rdata  out  WIDTH  read data; holds its last value when rvalid is low
- init_busy  out  1  fill in progress
- init_done  out  1  fill complete; stays high until the next reset
- err  out  1  one-cycle pulse on an out-of-range access

## Operation
- States: INIT and RUN. reset forces INIT, fill pointer = LO, rr_ptr = A.
- INIT:
  - Each non-reset edge writes mem[ptr] = ptr, zero-extended to WIDTH, then increments ptr.
  - After the write at LO+DEPTH-1, the FSM moves to RUN.
  - a_gnt and b_gnt stay 0 throughout; pending requests wait.
- RUN arbitration, evaluated every cycle:
  - Only one req high: that requester is granted.
  - Both high: the requester selected by rr_ptr is granted.
  - After any grant, rr_ptr points to the requester that was not granted.
  - At most one access per cycle; at most one gnt high.
- Write (gnt and we): mem[addr] = wdata on the grant edge.
- Read (gnt and !we): rdata = mem[addr] and rvalid = 1 in the following cycle, on the granted port only.
- Out-of-range address (addr < LO or addr > LO+DEPTH-1):
  - The request is still granted.
  - A write is dropped; the array is unchanged.
  - A read returns 0 with rvalid = 1.
  - err pulses in the cycle after the grant.
- Reset in the middle of INIT or RUN: the fill restarts from LO. In-flight rvalid/err pulses are cancelled. Array contents are not cleared by reset itself; only the fill overwrites them.

## Timing
- Reset values: a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0, err = 0, init_done = 0, init_busy = 1.
- Fill duration: init_busy stays high for exactly DEPTH cycles after the first edge with reset low. In the next cycle init_busy = 0 and init_done = 1, and grants can assert in that same cycle.
- Grant latency: 0 cycles (combinational from req in RUN).
- Read latency: 1 cycle from the grant edge to rvalid.
- Write visibility: a read granted the cycle after a write to the same address returns the new data.
- Sustained throughput: one access per cycle. A single requester with req held high is granted every cycle.

## Test plan
- Fill check: release reset and wait for init_done. Port A reads 1..16 back-to-back. Required: rdata equals 1..16, each on the rvalid cycle after its grant. init_busy stays high for exactly 16 cycles.
- Contention: a_req and b_req both held high for 6 cycles after init. Required grant order: A, B, A, B, A, B.
- Write/readback: A writes 0xDEADBEEF to index 7, then B reads 7 in the next cycle. Required: b_rvalid one cycle after b_gnt with b_rdata = 0xDEADBEEF.
- Out of range: A writes index 0, then reads index 17. Required: both granted, err pulses twice, read returns 0 with rvalid = 1. A readback of entries 1 and 16 returns 1 and 16.
- Reset mid-fill: assert reset on fill cycle 5 while a_req is high. Required: no grant during the fill. init_busy stays high for 16 cycles after reset releases, then a_gnt asserts and memory contents equal their indices.
- Request during fill: b_req is raised at fill cycle 2 and held. Required: b_gnt stays 0 until the first RUN cycle, then asserts.
